// File: rtl/strobe_serial_tx.sv
// strobe_serial_tx: MSB-first serialiser driving a data line plus a level enable strobe for latch receivers.
// Optional STROBE_TX_PARITY_EN appends an even-parity bit slot after the data bits.
module strobe_serial_tx #(
  parameter int WIDTH         = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             en_out,
  output logic             busy,
  output logic             done
);
`ifdef STROBE_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int PMAX = (SETUP_CYCLES > STROBE_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int PW = $clog2(PMAX + 1);
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] word;
  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] sh_next;
  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    p_last;
  logic [BW-1:0]    bcnt;
  logic             p_end;

`ifdef STROBE_TX_PARITY_EN
  assign word = {in_data, ^in_data};
`else
  assign word = in_data;
`endif

  assign sh_next  = sh << 1;
  assign in_ready = (state == IDLE) & ~rst;

  always_comb begin
    p_last = state == SETUP  ? PW'(SETUP_CYCLES - 1) :
             state == STROBE ? PW'(STROBE_CYCLES - 1) : PW'(HOLD_CYCLES - 1);
    p_end  = pcnt == p_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      pcnt   <= '0;
      bcnt   <= '0;
      d_out  <= 1'b0;
      en_out <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d_out  <= 1'b0;
          en_out <= 1'b0;
          if (in_valid) begin
            sh    <= word;
            d_out <= word[NBITS-1];
            pcnt  <= '0;
            bcnt  <= '0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          pcnt <= p_end ? '0 : pcnt + PW'(1);
          if (p_end) begin
            en_out <= 1'b1;
            state  <= STROBE;
          end
        end
        STROBE: begin
          pcnt <= p_end ? '0 : pcnt + PW'(1);
          if (p_end) begin
            en_out <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          pcnt <= p_end ? '0 : pcnt + PW'(1);
          // d_out only moves here, after the hold window of the current bit
          if (p_end && bcnt == BW'(NBITS - 1)) begin
            d_out <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (p_end) begin
            sh    <= sh_next;
            d_out <= sh_next[NBITS-1];
            bcnt  <= bcnt + BW'(1);
            state <= SETUP;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          d_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_strobe_serial_tx.sv
// tb_strobe_serial_tx: checks two transmitter configurations against a slot-timing model and a latch-capture model.
module tb_strobe_serial_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic va = 1'b0, vb = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic ra, d_a, en_a, busy_a, done_a;
  logic rb, d_b, en_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

`ifdef STROBE_TX_PARITY_EN
  localparam int NB = 9;
  localparam int LAT_A = 37;
  localparam int LAT_B = 55;
  localparam logic [15:0] CAP_A5 = 16'h014A;
  localparam logic [15:0] CAP_07 = 16'h000F;
  localparam logic [15:0] CAP_5A = 16'h00B4;
`else
  localparam int NB = 8;
  localparam int LAT_A = 33;
  localparam int LAT_B = 49;
  localparam logic [15:0] CAP_A5 = 16'h00A5;
  localparam logic [15:0] CAP_07 = 16'h0007;
  localparam logic [15:0] CAP_5A = 16'h005A;
`endif

  strobe_serial_tx dut_a (
    .clk(clk), .rst(rst), .in_data(da), .in_valid(va), .in_ready(ra),
    .d_out(d_a), .en_out(en_a), .busy(busy_a), .done(done_a)
  );

  strobe_serial_tx #(.WIDTH(8), .SETUP_CYCLES(2), .STROBE_CYCLES(1), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(db), .in_valid(vb), .in_ready(rb),
    .d_out(d_b), .en_out(en_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int          sel;
    logic [7:0]  word;
    logic [15:0] cap;
    int          lat;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin vb = v; db = d; end
    else begin va = v; da = d; end
  endtask

  function automatic logic [4:0] outs(input int sel);
    return (sel != 0) ? {rb, busy_b, done_b, en_b, d_b} : {ra, busy_a, done_a, en_a, d_a};
  endfunction

  function automatic logic [15:0] exp_cap(input logic [7:0] w);
    logic [15:0] c;
    c = {8'h00, w};
    if (NB == 9) c = {c[14:0], 1'($countones(w) % 2)};
    return c;
  endfunction

  // Waveform reference: slot index and offset derived from elapsed cycles since accept.
  task automatic send(input int sel, input logic [7:0] w, input bit hv, input logic [7:0] hw,
                      output logic [15:0] cap, output int lat);
    int su, st, ho, s, slot, off, pulses;
    logic [15:0] bits;
    logic [4:0] got, exp;
    logic pen;
    su = (sel != 0) ? 2 : 1;
    st = (sel != 0) ? 1 : 2;
    ho = (sel != 0) ? 3 : 1;
    s = su + st + ho;
    bits = exp_cap(w);
    got = outs(sel);
    chk("ready_before", 32'(got[4]), 1);
    drive(sel, 1'b1, w);
    @(negedge clk);
    drive(sel, hv, hv ? hw : 8'h00);
    cap = '0; lat = -1; pen = 1'b0; pulses = 0;
    for (int k = 1; k <= NB * s + 1; k++) begin
      if (k > 1) @(negedge clk);
      got = outs(sel);
      if (k <= NB * s) begin
        slot = (k - 1) / s;
        off  = (k - 1) % s;
        exp  = {1'b0, 1'b1, 1'b0, 1'(off >= su && off < su + st), bits[NB-1-slot]};
      end else exp = 5'b01100;
      chk("wave", 32'(got), 32'(exp));
      if (pen && !got[1]) begin cap = {cap[14:0], got[0]}; pulses++; end
      if (got[2] && lat < 0) lat = k;
      pen = got[1];
    end
    @(negedge clk);
    got = outs(sel);
    chk("idle_after", 32'(got), 32'(5'b10000));
    chk("pulses", 32'(pulses), 32'(NB));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [7:0] w;
    logic [4:0] got;
    int lat, sel, seen;
    tbl[0] = '{0, 8'hA5, CAP_A5, LAT_A};
    tbl[1] = '{0, 8'h07, CAP_07, LAT_A};
    tbl[2] = '{1, 8'h5A, CAP_5A, LAT_B};

    va = 1'b1; da = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst_outs_a", 32'(outs(0)), 0);
    chk("rst_outs_b", 32'(outs(1)), 0);
    rst = 1'b0; va = 1'b0;
    @(negedge clk);
    chk("ready_after_init", 32'(outs(0)), 32'(5'b10000));

    for (int i = 0; i < 3; i++) begin
      send(tbl[i].sel, tbl[i].word, 1'b0, 8'h00, cap, lat);
      chk("tbl_cap", 32'(cap), 32'(tbl[i].cap));
      chk("tbl_lat", 32'(lat), 32'(tbl[i].lat));
    end

    send(0, 8'h3C, 1'b1, 8'hFF, cap, lat);
    chk("busy_ignore_cap", 32'(cap), 32'(exp_cap(8'h3C)));
    send(0, 8'hFF, 1'b0, 8'h00, cap, lat);
    chk("held_word_cap", 32'(cap), 32'(exp_cap(8'hFF)));

    drive(0, 1'b1, 8'hF0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (9) @(negedge clk);
    got = outs(0);
    chk("pre_rst_strobe", 32'(got[1:0]), 32'(2'b11));
    rst = 1'b1;
    #1;
    chk("rst_mid_word", 32'(outs(0)), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a || busy_a || en_a) seen++;
    end
    chk("no_done_after_rst", 32'(seen), 0);
    send(0, 8'h81, 1'b0, 8'h00, cap, lat);
    chk("post_rst_cap", 32'(cap), 32'(exp_cap(8'h81)));

    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom);
      sel = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(sel, w, 1'b0, 8'h00, cap, lat);
      chk("rand_cap", 32'(cap), 32'(exp_cap(w)));
      chk("rand_lat", 32'(lat), 32'(NB * ((sel != 0) ? 6 : 4) + 1));
    end

    drive(0, 1'b1, 8'h55);
    rst = 1'b1;
    #1;
    chk("rst_pulse_outs", 32'(outs(0)), 0);
    @(posedge clk);
    #1;
    chk("rst_no_accept", 32'(outs(0)), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ready_after_rst", 32'(outs(0)), 32'(5'b10000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
